match_engine: RTL

//  Parametrised selection/match controller for the card-matching game: holds NUM_CARDS symbols,

---
 rtl/match_pkg.sv | 15 +
 rtl/match_engine_if.sv | 23 ++
 rtl/match_compare.sv | 31 +++
 rtl/match_engine.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared encodings for the card-matching selection engine.
package match_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_COMPARE = 3'd2,
    S_ERASE   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic MODE_UNHILITE = 1'b0;
  localparam logic MODE_REMOVE   = 1'b1;

endpackage

// File: rtl/match_engine_if.sv
// Selection handshake (input logic -> engine) and erase command channel (engine -> drawer).
interface match_engine_if #(
  parameter int IDX_W = 4
);
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_ready;
  logic             sel_err;
  logic             erase_req;
  logic [IDX_W-1:0] erase_idx;
  logic             erase_mode;
  logic             erase_ack;

  modport master (
    output sel_valid, sel_idx, erase_ack,
    input  sel_ready, sel_err, erase_req, erase_idx, erase_mode
  );

  modport slave (
    input  sel_valid, sel_idx, erase_ack,
    output sel_ready, sel_err, erase_req, erase_idx, erase_mode
  );
endinterface

// File: rtl/match_compare.sv
// GROUP-way symbol equality: looks up each slot's card symbol and checks all match slot 0.
module match_compare #(
  parameter int NUM_CARDS = 9,
  parameter int SYM_W     = 2,
  parameter int GROUP     = 3,
  parameter int IDX_W     = 4
) (
  input  logic [NUM_CARDS-1:0][SYM_W-1:0] sym,
  input  logic [GROUP-1:0][IDX_W-1:0]     slot,
  output logic                            all_eq
);

  logic [GROUP-1:0][SYM_W-1:0] gsym;
  logic [GROUP-1:0]            eq;

  // Explicit mux keeps the lookup width-safe for any IDX_W >= clog2(NUM_CARDS).
  always_comb begin
    gsym = '0;
    for (int g = 0; g < GROUP; g++)
      for (int c = 0; c < NUM_CARDS; c++)
        if (slot[g] == IDX_W'(c)) gsym[g] = sym[c];
  end

  assign eq[0] = 1'b1;
  for (genvar g = 1; g < GROUP; g++) begin : g_eq
    assign eq[g] = (gsym[g] == gsym[0]);
  end

  assign all_eq = &eq;

endmodule

// File: rtl/match_engine.sv
// Card-match controller: collects GROUP selections, compares, drives drawer erase handshake,
// tracks score / cleared cards and flags game over.
module match_engine
  import match_pkg::*;
#(
  parameter int NUM_CARDS = 9,
  parameter int SYM_W     = 2,
  parameter int GROUP     = 3,
  parameter int IDX_W     = 4,
  parameter int SCORE_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [NUM_CARDS*SYM_W-1:0] symbols_in,
  match_engine_if.slave              bus,
  output logic                       match_pulse,
  output logic                       miss_pulse,
  output logic [SCORE_W-1:0]         score,
  output logic [NUM_CARDS-1:0]       selected_mask,
  output logic [NUM_CARDS-1:0]       cleared_mask,
  output logic                       game_over
);

  localparam int CNT_W = $clog2(GROUP + 1);
  localparam int PC_W  = $clog2(NUM_CARDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARDS - 1);

  state_e                          state, state_nxt;
  logic [NUM_CARDS-1:0][SYM_W-1:0] sym_q;
  logic [GROUP-1:0][IDX_W-1:0]     slot;
  logic [CNT_W-1:0]                sel_cnt, ers_cnt;
  logic                            mode_q, sel_err_q, all_eq;
  logic [NUM_CARDS-1:0]            sel_oh, cleared_nxt;
  logic                            reject, accept, ack_hit, last_ack;
  logic [IDX_W-1:0]                cur_idx;
  logic [PC_W-1:0]                 uncleared;

  match_compare #(
    .NUM_CARDS (NUM_CARDS),
    .SYM_W     (SYM_W),
    .GROUP     (GROUP),
    .IDX_W     (IDX_W)
  ) u_cmp (
    .sym    (sym_q),
    .slot   (slot),
    .all_eq (all_eq)
  );

  // Selection decode, erase slot lookup and remaining-card count.
  always_comb begin
    sel_oh = '0;
    for (int c = 0; c < NUM_CARDS; c++)
      if (bus.sel_idx == IDX_W'(c)) sel_oh[c] = 1'b1;

    reject = bus.sel_valid && (state == S_SELECT) &&
             ((bus.sel_idx > LAST_IDX) || (|(sel_oh & (cleared_mask | selected_mask))));
    accept = bus.sel_valid && (state == S_SELECT) && !reject;

    cur_idx = '0;
    for (int g = 0; g < GROUP; g++)
      if (ers_cnt == CNT_W'(g)) cur_idx = slot[g];

    ack_hit  = (state == S_ERASE) && bus.erase_ack;
    last_ack = ack_hit && (ers_cnt == CNT_W'(GROUP - 1));

    cleared_nxt = cleared_mask | (mode_q ? selected_mask : '0);
    uncleared   = '0;
    for (int c = 0; c < NUM_CARDS; c++)
      uncleared = uncleared + PC_W'(!cleared_nxt[c]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.sel_ready  = 1'b0;
    bus.erase_req  = 1'b0;
    bus.erase_idx  = '0;
    bus.erase_mode = mode_q;
    match_pulse    = 1'b0;
    miss_pulse     = 1'b0;
    game_over      = 1'b0;
    case (state)
      S_IDLE: ;
      S_SELECT: begin
        bus.sel_ready = 1'b1;
        if (accept && (sel_cnt == CNT_W'(GROUP - 1))) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        match_pulse = all_eq;
        miss_pulse  = !all_eq;
        state_nxt   = S_ERASE;
      end
      S_ERASE: begin
        bus.erase_req = 1'b1;
        bus.erase_idx = cur_idx;
        if (last_ack) state_nxt = (uncleared < PC_W'(GROUP)) ? S_DONE : S_SELECT;
      end
      S_DONE:  game_over = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
    // start wins from any state, including mid-erase
    if (start) state_nxt = S_SELECT;
  end

  assign bus.sel_err = sel_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_q         <= '0;
      slot          <= '0;
      sel_cnt       <= '0;
      ers_cnt       <= '0;
      mode_q        <= MODE_UNHILITE;
      sel_err_q     <= 1'b0;
      score         <= '0;
      selected_mask <= '0;
      cleared_mask  <= '0;
    end else if (start) begin
      sym_q         <= symbols_in;
      slot          <= '0;
      sel_cnt       <= '0;
      ers_cnt       <= '0;
      mode_q        <= MODE_UNHILITE;
      sel_err_q     <= 1'b0;
      score         <= '0;
      selected_mask <= '0;
      cleared_mask  <= '0;
    end else begin
      sel_err_q <= reject;
      if (accept) begin
        for (int g = 0; g < GROUP; g++)
          if (sel_cnt == CNT_W'(g)) slot[g] <= bus.sel_idx;
        selected_mask <= selected_mask | sel_oh;
        sel_cnt       <= sel_cnt + 1'b1;
      end
      if (state == S_COMPARE) begin
        mode_q <= all_eq ? MODE_REMOVE : MODE_UNHILITE;
        if (all_eq && (score != {SCORE_W{1'b1}})) score <= score + 1'b1;
      end
      if (ack_hit) begin
        if (last_ack) begin
          cleared_mask  <= cleared_nxt;
          selected_mask <= '0;
          sel_cnt       <= '0;
          ers_cnt       <= '0;
        end else begin
          ers_cnt <= ers_cnt + 1'b1;
        end
      end
    end
  end

endmodule
